// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU/memory types used by the memory arbiter and its bench.
//   word_t      : 32-bit machine word
//   ramstate_t  : RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : memory arbiter FSM state. The literals carry an ARB_
//                 prefix because BUSY is already taken by ramstate_t.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Round-robin selector. It scans the request vector starting at ptr and
//   wraps modulo CPUS. It reports the first requesting index and whether
//   any request was found.
// Ports:
//   req   in  CPUS   request per core
//   ptr   in  PTR_W  core with highest priority this round
//   idx   out PTR_W  winning core (0 when valid=0)
//   valid out 1      at least one request present
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int PTR_W = 1
) (
    input  logic [CPUS-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int               c;
        logic [PTR_W-1:0] cand;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        cand  = '0;
        for (int k = 0; k < CPUS; k++) begin
            c    = (int'(ptr) + k) % CPUS;
            cand = PTR_W'(c);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single RAM port among CPUS cores. Each core has one
//   instruction-fetch port and one data port. Cores are served
//   round-robin. Within a core, the data port wins over the instruction
//   port. Cores that lose arbitration are stalled through iwait/dwait.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN):
//   A grant stuck in BUSY without ACCESS for TIMEOUT_CYCLES cycles is
//   released. arb_timeout then pulses for one cycle and the round-robin
//   pointer advances. When the macro is undefined, BUSY holds
//   indefinitely and arb_timeout is tied to 0.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN/iaddr           instruction read request and address, per core
//   dREN/dWEN/daddr      data read/write request and address, per core
//   dstore               data write value, per core
//   iwait/dwait          1 = access of that port not yet complete
//   iload/dload          ramload broadcast to every core
//   ramREN/ramWEN        RAM strobes
//   ramaddr/ramstore     RAM address and write data
//   ramload/ramstate     RAM read data and handshake state
//   arb_busy             1 while a grant is outstanding
//   arb_timeout          one-cycle pulse on a forced release
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  word_t [CPUS-1:0]     iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output word_t [CPUS-1:0]     iload,
    output word_t [CPUS-1:0]     dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    output logic                 arb_busy,
    output logic                 arb_timeout
);

    localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    if (CPUS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: CPUS and TIMEOUT_CYCLES must both be >= 1");
    end

    arb_state_t       state;
    logic [PTR_W-1:0] grant_core;
    logic             grant_is_data;
    logic [PTR_W-1:0] rr_ptr;

    logic [CPUS-1:0]  dreq;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic             grant_live;
    logic             done;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(CPUS - 1)) return '0;
        else                       return p + 1'b1;
    endfunction

    assign dreq = dREN | dWEN;

    rr_pick #(
        .CPUS  (CPUS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (iREN | dreq),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // The granted port must still be requesting. A withdrawn request
    // releases the grant without counting as a completed access.
    assign grant_live = grant_is_data ? dreq[grant_core] : iREN[grant_core];
    assign done       = (state == ARB_BUSY) && grant_live && (ramstate == ACCESS);
    assign arb_busy   = (state == ARB_BUSY);

    // RAM side follows the granted port's live request, so a withdrawn
    // request drops its strobe in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state == ARB_BUSY) begin
            if (grant_is_data) begin
                ramWEN   = dWEN[grant_core];
                ramREN   = dREN[grant_core] & ~dWEN[grant_core];
                ramaddr  = daddr[grant_core];
                ramstore = dstore[grant_core];
            end else begin
                ramREN   = iREN[grant_core];
                ramaddr  = iaddr[grant_core];
            end
        end
    end

    always_comb begin
        iwait = iREN;
        dwait = dreq;
        if (done) begin
            if (grant_is_data) dwait[grant_core] = 1'b0;
            else               iwait[grant_core] = 1'b0;
        end
    end

    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] busy_cnt;
    logic             timeout_q;
    assign arb_timeout = timeout_q;
`else
    assign arb_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= ARB_IDLE;
            grant_core    <= '0;
            grant_is_data <= 1'b0;
            rr_ptr        <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state         <= ARB_BUSY;
                        grant_core    <= pick_idx;
                        grant_is_data <= dreq[pick_idx];
`ifdef MEM_ARB_TIMEOUT_EN
                        busy_cnt      <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (!grant_live) begin
                        state <= ARB_IDLE;
                    end else if (ramstate == ACCESS) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= ptr_inc(grant_core);
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Forced release. The requester keeps its wait
                        // high and competes again from IDLE.
                        state     <= ARB_IDLE;
                        rr_ptr    <= ptr_inc(grant_core);
                        timeout_q <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
`endif
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int TO   = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [CPUS-1:0]  iREN, dREN, dWEN;
    word_t [CPUS-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]  iwait, dwait;
    word_t [CPUS-1:0] iload, dload;
    logic             ramREN, ramWEN;
    word_t            ramaddr, ramstore, ramload;
    ramstate_t        ramstate;
    logic             arb_busy, arb_timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: the owner is -1 when nothing is granted, otherwise
    // it is core*2 + (1 for a data grant). m_rr is the core scanned first.
    int   m_owner;
    int   m_rr;
    int   m_busy_cnt;
    logic m_to;

    mem_arbiter #(.CPUS(CPUS), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .arb_busy(arb_busy), .arb_timeout(arb_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_rr       = 0;
        m_busy_cnt = 0;
        m_to       = 1'b0;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = 32'h1234_5678;
        ramstate = FREE;
    endtask

    function automatic logic port_req(input int owner);
        bit c;
        c = 1'(owner / 2);
        if ((owner % 2) == 1) return dREN[c] | dWEN[c];
        else                  return iREN[c];
    endfunction

    task automatic compare_all();
        logic [CPUS-1:0] ei, ed;
        logic  er, ew;
        word_t ea, es;
        bit    c;
        ei = iREN; ed = dREN | dWEN;
        er = 1'b0; ew = 1'b0; ea = '0; es = '0;
        if (nRST && m_owner >= 0) begin
            c = 1'(m_owner / 2);
            if ((m_owner % 2) == 1) begin
                ew = dWEN[c];
                er = dREN[c] & ~dWEN[c];
                ea = daddr[c];
                es = dstore[c];
            end else begin
                er = iREN[c];
                ea = iaddr[c];
            end
            if (port_req(m_owner) && ramstate == ACCESS) begin
                if ((m_owner % 2) == 1) ed[c] = 1'b0;
                else                    ei[c] = 1'b0;
            end
        end
        chk("iwait",       64'(iwait),       64'(ei));
        chk("dwait",       64'(dwait),       64'(ed));
        chk("ramREN",      64'(ramREN),      64'(er));
        chk("ramWEN",      64'(ramWEN),      64'(ew));
        chk("ramaddr",     64'(ramaddr),     64'(ea));
        chk("ramstore",    64'(ramstore),    64'(es));
        chk("arb_busy",    64'(arb_busy),    64'(nRST && m_owner >= 0));
        chk("arb_timeout", 64'(arb_timeout), 64'(m_to));
        chk("iload0",      64'(iload[0]),    64'(ramload));
        chk("dload1",      64'(dload[1]),    64'(ramload));
    endtask

    task automatic model_step();
        int c;
        m_to = 1'b0;
        if (!nRST) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            for (int k = 0; k < CPUS; k++) begin
                c = (m_rr + k) % CPUS;
                if (iREN[1'(c)] | dREN[1'(c)] | dWEN[1'(c)]) begin
                    m_owner    = c * 2 + ((dREN[1'(c)] | dWEN[1'(c)]) ? 1 : 0);
                    m_busy_cnt = 0;
                    break;
                end
            end
        end else begin
            c = m_owner / 2;
            if (!port_req(m_owner)) begin
                m_owner = -1;
            end else if (ramstate == ACCESS) begin
                m_owner = -1;
                m_rr    = (c + 1) % CPUS;
            end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                m_busy_cnt++;
                if (m_busy_cnt == TO) begin
                    m_owner = -1;
                    m_rr    = (c + 1) % CPUS;
                    m_to    = 1'b1;
                end
`endif
            end
        end
    endtask

    // One clock cycle: inputs have been set just after a falling edge.
    task automatic tick();
        #1;
        compare_all();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        model_reset();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge CLK);

        // Reset state: waits follow requests, no strobes, not busy
        iREN = 2'b11;
        iaddr[0] = 32'h40; iaddr[1] = 32'h80;
        #1;
        chk("rst_ramREN", 64'(ramREN),   64'd0);
        chk("rst_iwait",  64'(iwait),    64'(2'b11));
        chk("rst_busy",   64'(arb_busy), 64'd0);
        tick();
        nRST = 1'b1;
        tick();
        #1;
        chk("rst_first_core0", 64'(ramaddr), 64'h40);
        tick();

        // Data beats instruction within core 0
        do_reset();
        iREN[0] = 1'b1; dREN[0] = 1'b1;
        daddr[0] = 32'h100; iaddr[0] = 32'h40;
        tick();
        tick();
        ramstate = ACCESS;
        #1;
        chk("prio_addr",  64'(ramaddr),  64'h100);
        chk("prio_dwait", 64'(dwait[0]), 64'd0);
        chk("prio_iwait", 64'(iwait[0]), 64'd1);
        tick();
        dREN[0] = 1'b0;
        tick();
        #1;
        chk("prio_iaddr",  64'(ramaddr),  64'h40);
        chk("prio_iwait2", 64'(iwait[0]), 64'd0);
        tick();

        // Round-robin alternation with ACCESS on every busy cycle
        do_reset();
        iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20;
        ramstate = ACCESS;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] e;
            e = (k % 2 == 0) ? 2'b11 : (((k / 2) % 2 == 0) ? 2'b10 : 2'b01);
            #1;
            chk("rr_iwait", 64'(iwait), 64'(e));
            tick();
        end

        // Write, then write+read asserted together
        do_reset();
        dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'hDEAD_BEEF;
        tick();
        #1;
        chk("wr_wen",   64'(ramWEN),   64'd1);
        chk("wr_ren",   64'(ramREN),   64'd0);
        chk("wr_store", 64'(ramstore), 64'hDEAD_BEEF);
        chk("wr_addr",  64'(ramaddr),  64'h200);
        dREN[1] = 1'b1;
        #1;
        chk("wrrd_wen", 64'(ramWEN),   64'd1);
        chk("wrrd_ren", 64'(ramREN),   64'd0);
        chk("wrrd_store", 64'(ramstore), 64'hDEAD_BEEF);
        tick();

        // Withdraw while busy, then reset in the middle of an access
        do_reset();
        dREN[0] = 1'b1; daddr[0] = 32'h300;
        iaddr[0] = 32'h44; iaddr[1] = 32'h88;
        tick();
        #1;
        chk("wd_ren_on", 64'(ramREN), 64'd1);
        dREN[0] = 1'b0;
        #1;
        chk("wd_ren_drop", 64'(ramREN), 64'd0);
        tick();
        #1;
        chk("wd_idle", 64'(arb_busy), 64'd0);
        iREN = 2'b11;
        tick();
        #1;
        chk("wd_rr_kept", 64'(ramaddr), 64'h44);
        chk("mid_ren_on", 64'(ramREN),  64'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_ren",  64'(ramREN),   64'd0);
        chk("mid_rst_wen",  64'(ramWEN),   64'd0);
        chk("mid_rst_busy", 64'(arb_busy), 64'd0);
        chk("mid_rst_addr", 64'(ramaddr),  64'd0);
        model_reset();
        tick();
        nRST = 1'b1;
        tick();
        tick();

        // RAM stuck in BUSY
        do_reset();
        dREN[0] = 1'b1; daddr[0] = 32'h400; daddr[1] = 32'h500;
        ramstate = BUSY;
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            #1;
            chk("to_busy",  64'(arb_busy),    64'd1);
            chk("to_pulse0", 64'(arb_timeout), 64'd0);
            tick();
        end
        dREN[1] = 1'b1;
        #1;
        chk("to_pulse", 64'(arb_timeout), 64'd1);
        chk("to_idle",  64'(arb_busy),    64'd0);
        chk("to_dwait", 64'(dwait[0]),    64'd1);
        tick();
        #1;
        chk("to_rr_adv",  64'(ramaddr),     64'h500);
        chk("to_pulse_end", 64'(arb_timeout), 64'd0);
        tick();
`else
        for (int k = 0; k < 120; k++) begin
            #1;
            chk("hold_busy",  64'(arb_busy), 64'd1);
            chk("hold_dwait", 64'(dwait[0]), 64'd1);
            tick();
        end
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int r;
            for (int c = 0; c < CPUS; c++) begin
                iREN[1'(c)] = ($urandom_range(0, 9) < 5);
                dREN[1'(c)] = ($urandom_range(0, 9) < 4);
                dWEN[1'(c)] = ($urandom_range(0, 9) < 3);
                iaddr[1'(c)]  = $urandom;
                daddr[1'(c)]  = $urandom;
                dstore[1'(c)] = $urandom;
            end
            r = $urandom_range(0, 5);
            ramstate = (r >= 3) ? ACCESS : ramstate_t'(r[1:0]);
            ramload  = $urandom;
            if (n == 300) begin
                nRST = 1'b0;
                tick();
                nRST = 1'b1;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
